// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential packed-BCD to unsigned binary converter. It performs
//            one multiply-by-ten-and-add per clock under a start/busy/done
//            handshake. Optional macro BCD_CHECK_EN adds invalid-digit
//            detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
  parameter int NDIGITS = 8,
  parameter int BW      = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [BW-1:0]          binary,
  output logic                   err
);

  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [4*NDIGITS-1:0] r_shift;
  logic [BW-1:0]        r_acc;
  logic [BW-1:0]        w_sum;
  logic [CW-1:0]        r_cnt;
  logic                 w_last;

  // acc*10 built from two shifts so no multiplier is inferred
  assign w_sum  = (r_acc << 3) + (r_acc << 1) + BW'(r_shift[4*NDIGITS-1 -: 4]);
  assign w_last = (r_cnt == CW'(NDIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_CONV;
      S_CONV: begin
        busy = 1'b1;
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic w_bad;
  logic r_invalid;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      done      <= 1'b0;
      binary    <= '0;
`ifdef BCD_CHECK_EN
      r_invalid <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_shift   <= bcd_in;
          r_acc     <= '0;
          r_cnt     <= '0;
`ifdef BCD_CHECK_EN
          r_invalid <= w_bad;
`endif
        end
      end else begin
        r_acc   <= w_sum;
        r_shift <= r_shift << 4;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          done <= 1'b1;
`ifdef BCD_CHECK_EN
          binary <= r_invalid ? '0 : w_sum;
          err    <= r_invalid;
`else
          binary <= w_sum;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// Module   : tb_bcd_to_bin_seq
// Purpose  : Self-checking bench for bcd_to_bin_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

  localparam int NDIGITS = 8;
  localparam int BW      = 27;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [4*NDIGITS-1:0] bcd_in;
  logic                 busy;
  logic                 done;
  logic [BW-1:0]        binary;
  logic                 err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_to_bin_seq #(.NDIGITS(NDIGITS), .BW(BW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Positional decimal weighting, reduced modulo 2^BW at the end.
  function automatic logic [31:0] model_bin(input logic [31:0] v);
    longint acc = 0;
    longint pw  = 1;
    for (int i = 0; i < NDIGITS; i++) begin
      acc += longint'((v >> (4*i)) & 32'hF) * pw;
      pw  *= 10;
    end
`ifdef BCD_CHECK_EN
    if (model_err(v) != 0) return 32'd0;
`endif
    return 32'(acc % (longint'(1) << BW));
  endfunction

  function automatic logic [31:0] model_err(input logic [31:0] v);
`ifdef BCD_CHECK_EN
    for (int i = 0; i < NDIGITS; i++)
      if (((v >> (4*i)) & 32'hF) > 9) return 32'd1;
`endif
    return (v == 32'hFFFF_FFFF && v != v) ? 32'd1 : 32'd0;
  endfunction

  task automatic run_conv(input logic [31:0] v, input string tag);
    int lat = 0;
    int busy_cnt = 0;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      busy_cnt += int'(busy);
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_cnt, NDIGITS);
    check({tag, "_binary"}, 32'(binary), model_bin(v));
    check({tag, "_err"}, 32'(err), model_err(v));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] v;
    logic [31:0] alt [2];

    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_binary", 32'(binary), 0);
    check("reset_err", 32'(err), 0);
    reset = 1'b0;

    run_conv(32'h0000_7891, "c7891");
    run_conv(32'h9999_9999, "cmax");
    check("cmax_const", 32'(binary), 32'h05F5_E0FF);
    run_conv(32'h0000_0000, "czero");

    // Inputs and start changed mid-conversion must be ignored.
    @(negedge clk);
    bcd_in = 32'h0001_2345;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin bcd_in = 32'h0000_0042; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    check("disturb_latency", lat, 9);
    check("disturb_binary", 32'(binary), 12345);
    dones = 0;
    repeat (12) begin @(negedge clk); dones += int'(done); end
    check("disturb_no_extra_done", dones, 0);
    run_conv(32'h0000_0042, "c42");

    // Reset in the middle of a conversion aborts without a done pulse.
    @(negedge clk);
    bcd_in = 32'h0000_7891;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      dones += int'(done);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_binary", 32'(binary), 0);
    reset = 1'b0;
    repeat (12) begin @(negedge clk); dones += int'(done); end
    check("abort_no_done", dones, 0);
    run_conv(32'h0000_7891, "after_abort");

    run_conv(32'h0000_001A, "c1A");

    // Start held high: back-to-back conversions every NDIGITS+1 cycles.
    alt[0] = 32'h0000_0001;
    alt[1] = 32'h0000_0010;
    @(negedge clk);
    bcd_in = alt[0];
    start  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (done) begin lat = k; break; end
      end
      check($sformatf("b2b%0d_interval", n), lat, 9);
      check($sformatf("b2b%0d_binary", n), 32'(binary), model_bin(alt[n % 2]));
      bcd_in = alt[(n + 1) % 2];
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Random legal digits and random raw nibbles.
    for (int t = 0; t < 24; t++) begin
      v = 32'h0;
      if (t < 16) begin
        for (int i = 0; i < NDIGITS; i++) v |= 32'($urandom_range(0, 9)) << (4*i);
      end else begin
        v = $urandom;
      end
      run_conv(v, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
